uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter feeding the uart_rx link. A CPU-side register port writes bytes into a 4-entry FIFO.

---
 rtl/uart_tx_mmio.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// uart_tx_mmio: register-mapped UART transmitter, 4-entry FIFO, SECDED(13,8) frames of 15 bit-times.
// Revision 1.0
module uart_tx_mmio #(
  parameter int DIVISOR    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] addr,
  input  logic       wr_en,
  input  logic [7:0] wdata,
  input  logic       rd_en,
  output logic [7:0] rdata,
  output logic       tx,
  output logic       busy
);

  localparam int CNT_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIVISOR - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [1:0]       ADDR_DATA = 2'd0;
  localparam logic [1:0]       ADDR_STAT = 2'd1;
  localparam logic [1:0]       ADDR_CTRL = 2'd2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [3:0]       bit_idx;
  logic [12:0]      shift_reg;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             enable;

  logic             fifo_empty;
  logic             fifo_full;
  logic             wr_data;
  logic             wr_ctrl;
  logic             push;
  logic             pop;
  logic             bit_end;
  logic [7:0]       head;
  logic [12:1]      ham;
  logic [12:0]      code;
  logic [7:0]       rd_mux;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign wr_data    = wr_en && (addr == ADDR_DATA);
  assign wr_ctrl    = wr_en && (addr == ADDR_CTRL);
  assign push       = wr_data && !fifo_full;
  assign bit_end    = (clk_cnt == LAST_CNT);
  assign pop        = enable && !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && bit_end));
  assign head       = mem[rd_ptr];

  // Hamming positions 1..12 with parity at the powers of two; code[0] is overall parity.
  always_comb begin
    ham     = '0;
    ham[3]  = head[0];
    ham[5]  = head[1];
    ham[6]  = head[2];
    ham[7]  = head[3];
    ham[9]  = head[4];
    ham[10] = head[5];
    ham[11] = head[6];
    ham[12] = head[7];
    ham[1]  = head[0] ^ head[1] ^ head[3] ^ head[4] ^ head[6];
    ham[2]  = head[0] ^ head[2] ^ head[3] ^ head[5] ^ head[6];
    ham[4]  = head[1] ^ head[2] ^ head[3] ^ head[7];
    ham[8]  = head[4] ^ head[5] ^ head[6] ^ head[7];
  end

  assign code = {ham, ^ham};

  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      ADDR_STAT: rd_mux = {4'b0000, overflow, fifo_empty, fifo_full, busy};
      ADDR_CTRL: rd_mux = {7'b0000000, enable};
      default:   rd_mux = 8'h00;
    endcase
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      enable   <= 1'b0;
      rdata    <= 8'h00;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A write into a full FIFO is lost even when the transmitter frees a slot that cycle.
      if (wr_data && fifo_full) begin
        overflow <= 1'b1;
      end else if (wr_ctrl && wdata[1]) begin
        overflow <= 1'b0;
      end
      if (wr_ctrl) begin
        enable <= wdata[0];
      end
      if (rd_en) begin
        rdata <= rd_mux;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= 4'd0;
      shift_reg <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          if (pop) begin
            shift_reg <= code;
            state     <= START;
            tx        <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= 4'd0;
            state   <= DATA;
            tx      <= shift_reg[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd12) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (pop) begin
              shift_reg <= code;
              state     <= START;
              tx        <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// tb_uart_tx_mmio: directed and randomized checks of uart_tx_mmio against a behavioural frame model.
module tb_uart_tx_mmio;

  localparam int DIV   = 10;
  localparam int FRAME = 15 * DIV;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [1:0] addr  = 2'd0;
  logic       wr_en = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] rdata;
  logic       tx;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [12:0] fr_code [$];
  logic        fr_stop [$];
  int          fr_t0   [$];
  logic [7:0]  exp_q   [$];

  uart_tx_mmio #(.DIVISOR(DIV), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_en(wr_en), .wdata(wdata),
    .rd_en(rd_en), .rdata(rdata), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference encoder: place data in the non-power-of-two positions, then derive parities.
  function automatic logic [12:0] enc(input logic [7:0] d);
    logic [12:0] c;
    logic        p;
    int          j;
    c = '0;
    j = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 4; k++) begin
      p = 1'b0;
      for (int pos = 1; pos <= 12; pos++)
        if ((((pos >> k) & 1) == 1) && (pos != (1 << k))) p ^= c[pos];
      c[1 << k] = p;
    end
    c[0] = ^c[12:1];
    return c;
  endfunction

  // Line receiver: samples each bit at its midpoint.
  initial begin : monitor
    logic [12:0] c;
    int          t0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0 || tx !== 1'b0) continue;
      t0 = cyc;
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 13; i++) begin
        repeat (DIV) @(negedge clk);
        c[i] = tx;
      end
      repeat (DIV) @(negedge clk);
      fr_code.push_back(c);
      fr_stop.push_back(tx);
      fr_t0.push_back(t0);
    end
  end

  initial begin : watchdog
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] v);
    addr  = a;
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    v     = rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr(2'd0, b);
    exp_q.push_back(b);
  endtask

  task automatic wait_tx_low(input string tag, output int t0);
    t0 = -1;
    for (int k = 0; k < 2 * FRAME; k++) begin
      if (tx === 1'b0) begin
        t0 = cyc;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_start_seen"}, (t0 >= 0), 1);
  endtask

  task automatic wait_check(input string tag, input int n, input bit b2b);
    int         budget;
    int         prev;
    logic [7:0] b;
    budget = n * FRAME + 60;
    prev   = 0;
    while (fr_code.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({tag, "_count"}, fr_code.size(), n);
    for (int i = 0; i < n && fr_code.size() > 0; i++) begin
      b = 8'h00;
      if (exp_q.size() > 0) b = exp_q.pop_front();
      chk({tag, "_code"}, fr_code[0], enc(b));
      chk({tag, "_stop"}, fr_stop[0], 1);
      if (b2b && i > 0) chk({tag, "_gap"}, fr_t0[0] - prev, FRAME);
      prev = fr_t0[0];
      void'(fr_code.pop_front());
      void'(fr_stop.pop_front());
      void'(fr_t0.pop_front());
    end
  endtask

  initial begin : stimulus
    logic [7:0] v;
    int         t0;
    int         k;

    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rdata", rdata, 0);
    rd(2'd1, v); chk("reset_status", v, 8'h04);
    rd(2'd2, v); chk("reset_ctrl", v, 8'h00);
    rd(2'd0, v); chk("read_txdata_zero", v, 8'h00);
    rd(2'd3, v); chk("read_addr3_zero", v, 8'h00);
    wr(2'd3, 8'hFF);
    rd(2'd2, v); chk("addr3_write_ignored_ctrl", v, 8'h00);
    rd(2'd1, v); chk("addr3_write_ignored_status", v, 8'h04);

    // Single frame, latency and length
    wr(2'd2, 8'h01);
    rd(2'd2, v); chk("ctrl_enable_read", v, 8'h01);
    push_byte(8'hA5);
    chk("latency_n1_tx", tx, 1);
    @(negedge clk);
    chk("latency_n2_tx", tx, 0);
    chk("busy_at_start", busy, 1);
    t0 = cyc;
    idle(140);
    chk("a5_stop_tx", tx, 1);
    chk("a5_stop_busy", busy, 1);
    idle(9);
    chk("a5_last_busy", busy, 1);
    idle(1);
    chk("a5_end_busy", busy, 0);
    chk("a5_end_tx", tx, 1);
    if (fr_code.size() > 0) chk("a5_code_literal", fr_code[0], 13'h144E);
    wait_check("a5", 1, 1'b0);

    push_byte(8'h00);
    wait_check("zero", 1, 1'b0);
    push_byte(8'hFF);
    wait_check("ones", 1, 1'b0);

    // Fill with transmitter held off, then overflow
    wr(2'd2, 8'h00);
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    rd(2'd1, v); chk("full_status", v, 8'h02);
    wr(2'd0, 8'h55);
    rd(2'd1, v); chk("overflow_status", v, 8'h0A);
    wr(2'd2, 8'h01);
    wait_check("burst4", 4, 1'b1);
    idle(10);
    rd(2'd1, v); chk("burst_done_status", v, 8'h0C);
    wr(2'd2, 8'h03);
    rd(2'd1, v); chk("overflow_cleared", v, 8'h04);
    rd(2'd2, v); chk("ctrl_after_clear", v, 8'h01);

    // Enable dropped mid-frame
    wr(2'd2, 8'h00);
    push_byte(8'h5A); push_byte(8'hC7); push_byte(8'h81);
    wr(2'd2, 8'h01);
    wait_tx_low("pause", t0);
    idle(60);
    wr(2'd2, 8'h00);
    idle(2 * FRAME);
    wait_check("pause_one", 1, 1'b0);
    rd(2'd1, v); chk("pause_status", v, 8'h00);
    wr(2'd2, 8'h01);
    wait_check("resume", 2, 1'b1);

    // Push into a full FIFO on the cycle the STOP-end pop frees a slot
    wr(2'd2, 8'h00);
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'h04);
    wr(2'd2, 8'h01);
    wait_tx_low("race", t0);
    idle(20);
    push_byte(8'h05);
    rd(2'd1, v); chk("race_full_status", v, 8'h03);
    idle(t0 + FRAME - 1 - cyc);
    wr(2'd0, 8'hEE);
    rd(2'd1, v); chk("race_drop_status", v, 8'h09);
    wait_check("race", 5, 1'b1);
    wr(2'd2, 8'h03);

    // Reset in the middle of data bit 6
    wr(2'd0, 8'h3C);
    wr(2'd0, 8'hC3);
    wait_tx_low("rst", t0);
    idle(t0 + DIV + 6 * DIV + DIV / 2 - cyc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_tx", tx, 1);
    chk("midreset_busy", busy, 0);
    rd(2'd1, v); chk("midreset_status", v, 8'h04);
    rd(2'd2, v); chk("midreset_ctrl", v, 8'h00);
    idle(FRAME);
    fr_code.delete(); fr_stop.delete(); fr_t0.delete();
    wr(2'd2, 8'h01);
    idle(2 * FRAME);
    chk("no_frame_after_reset", fr_code.size(), 0);

    // Randomized bursts
    for (int r = 0; r < 4; r++) begin
      wr(2'd2, 8'h00);
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) push_byte(8'($urandom));
      rd(2'd1, v);
      chk("rand_status_loaded", v, {4'b0000, 1'b0, 1'b0, (k == 4), 1'b0});
      wr(2'd2, 8'h01);
      wait_check("rand", k, 1'b1);
      idle(10);
      rd(2'd1, v); chk("rand_status_done", v, 8'h04);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
